// File: rtl/gen_fwft_queue_with_dpmem.sv
// First-word-fall-through queue over an inferred dual-port RAM with a 2-entry prefetch stage.
// Optional high-watermark tracking is enabled by defining GEN_FWFT_QUEUE_WATERMARK_EN.
module gen_fwft_queue_with_dpmem #(
   parameter int DATA_W  = 8,
   parameter int DEPTH   = 100,
   parameter int SIM_DLY = 1,
   localparam int DEPTH_W = $clog2(DEPTH + 3)
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic               sw_rst,
   input  logic [DEPTH_W-1:0] cnfg_depth,
   input  logic [DEPTH_W-1:0] cnfg_afull_th,
   input  logic [DEPTH_W-1:0] cnfg_aempty_th,
   input  logic               push,
   input  logic [DATA_W-1:0]  i_data,
   input  logic               pop,
   output logic [DATA_W-1:0]  o_data,
   output logic               o_valid,
   output logic               full,
   output logic               empty,
   output logic               afull,
   output logic               aempty,
   output logic [DEPTH_W-1:0] fullness,
   output logic               ovf_err,
   output logic               udf_err
`ifdef GEN_FWFT_QUEUE_WATERMARK_EN
   ,
   input  logic               wm_clr,
   output logic [DEPTH_W-1:0] max_fullness
`endif
);

   localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DATA_W-1:0]             mem [0:DEPTH-1];
   logic [DATA_W-1:0]             mem_rd_data;
   logic [ADDR_W-1:0]             head_ptr_r, tail_ptr_r, head_ptr_nx, tail_ptr_nx;
   logic [DEPTH_W-1:0]            mem_cnt_r, mem_cnt_nx, fullness_r, fullness_nx, depth_last;
   logic                          rd_pend_r;
   logic [1:0]                    out_occ_r, out_occ_nx;
   logic [1:0][DATA_W-1:0]        out_data_r, out_data_nx;
   logic                          full_r, empty_r, afull_r, aempty_r, ovf_r, udf_r;
   logic                          push_acc, pop_acc, rd_iss;
   logic [2:0]                    stage_load;

   // A returning read word is presented straight from the RAM output register, so a
   // word pushed into an empty queue is visible two cycles later.
   assign o_valid  = (out_occ_r != 2'd0) | rd_pend_r;
   assign o_data   = (out_occ_r == 2'd0 && rd_pend_r) ? mem_rd_data : out_data_r[0];
   assign push_acc = push & ~full_r;
   assign pop_acc  = pop & o_valid;

   assign stage_load = {1'b0, out_occ_r} + {2'b00, rd_pend_r} - {2'b00, pop_acc};
   assign rd_iss     = (mem_cnt_r != '0) && (stage_load < 3'd2);

   assign depth_last  = cnfg_depth - DEPTH_W'(1);
   assign tail_ptr_nx = !push_acc ? tail_ptr_r :
                        (DEPTH_W'(tail_ptr_r) == depth_last) ? '0 : tail_ptr_r + ADDR_W'(1);
   assign head_ptr_nx = !rd_iss ? head_ptr_r :
                        (DEPTH_W'(head_ptr_r) == depth_last) ? '0 : head_ptr_r + ADDR_W'(1);
   assign mem_cnt_nx  = mem_cnt_r + DEPTH_W'(push_acc) - DEPTH_W'(rd_iss);
   assign fullness_nx = fullness_r + DEPTH_W'(push_acc) - DEPTH_W'(pop_acc);

   always_comb begin
      out_data_nx = out_data_r;
      out_occ_nx  = out_occ_r;
      if (pop_acc && out_occ_r != 2'd0) begin
         out_data_nx[0] = out_data_r[1];
         out_occ_nx     = out_occ_r - 2'd1;
      end
      // A pending word popped straight off the RAM output never enters the stage.
      if (rd_pend_r && !(pop_acc && out_occ_r == 2'd0)) begin
         out_data_nx[out_occ_nx[0]] = mem_rd_data;
         out_occ_nx                 = out_occ_nx + 2'd1;
      end
   end

   generate
      if (SIM_DLY >= 0) begin : g_ram
         // Read-first RAM: a read and write in the same cycle return the old word.
         always_ff @(posedge clk) begin
            if (push_acc) mem[tail_ptr_r] <= i_data;
            if (rd_iss)   mem_rd_data     <= mem[head_ptr_r];
         end
      end else begin : g_no_ram
         assign mem_rd_data = '0;
      end
   endgenerate

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         head_ptr_r <= '0;  tail_ptr_r <= '0;  mem_cnt_r <= '0;  fullness_r <= '0;
         rd_pend_r  <= 1'b0; out_occ_r <= '0;  out_data_r <= '0;
         full_r <= 1'b0; empty_r <= 1'b1; afull_r <= 1'b0; aempty_r <= 1'b1;
         ovf_r  <= 1'b0; udf_r   <= 1'b0;
      end else if (sw_rst) begin
         head_ptr_r <= '0;  tail_ptr_r <= '0;  mem_cnt_r <= '0;  fullness_r <= '0;
         rd_pend_r  <= 1'b0; out_occ_r <= '0;  out_data_r <= '0;
         full_r <= 1'b0; empty_r <= 1'b1; afull_r <= 1'b0; aempty_r <= 1'b1;
         ovf_r  <= 1'b0; udf_r   <= 1'b0;
      end else begin
         head_ptr_r <= head_ptr_nx;
         tail_ptr_r <= tail_ptr_nx;
         mem_cnt_r  <= mem_cnt_nx;
         fullness_r <= fullness_nx;
         rd_pend_r  <= rd_iss;
         out_occ_r  <= out_occ_nx;
         out_data_r <= out_data_nx;
         full_r     <= (fullness_nx >= cnfg_depth + DEPTH_W'(2));
         empty_r    <= (fullness_nx == '0);
         afull_r    <= (fullness_nx >= cnfg_afull_th);
         aempty_r   <= (fullness_nx <= cnfg_aempty_th);
         if (push && full_r)   ovf_r <= 1'b1;
         if (pop && !o_valid)  udf_r <= 1'b1;
      end
   end

   assign fullness = fullness_r;
   assign full     = full_r;
   assign empty    = empty_r;
   assign afull    = afull_r;
   assign aempty   = aempty_r;
   assign ovf_err  = ovf_r;
   assign udf_err  = udf_r;

`ifdef GEN_FWFT_QUEUE_WATERMARK_EN
   logic [DEPTH_W-1:0] max_fullness_r;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)                         max_fullness_r <= '0;
      else if (sw_rst)                   max_fullness_r <= '0;
      else if (wm_clr)                   max_fullness_r <= fullness_r;
      else if (fullness_r > max_fullness_r) max_fullness_r <= fullness_r;
   end

   assign max_fullness = max_fullness_r;
`endif

endmodule
